// File: rtl/datapath_rr_arbiter_pkg.sv
// Shared definitions for the round-robin datapath arbiter: FSM state
// encoding, latency counter width and requester-index width helper.
package datapath_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Wide enough for DP_LATENCY-1 with DP_LATENCY up to 15.
  localparam int CNT_W = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/datapath_rr_arbiter_picker.sv
// Round-robin priority picker: finds the first asserted request at or above
// the pointer, wrapping at NUM_REQ, and reports it one-hot and as an index.
module rr_priority_picker
  import datapath_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  always_comb begin
    int idx;
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path through the block infers a latch.
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any_valid && req[idx]) begin
        any_valid     = 1'b1;
        grant_idx     = ID_W'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/datapath_rr_arbiter.sv
// Shares one fixed-latency datapath between NUM_REQ requesters: round-robin
// grant, a single transaction in flight, result returned tagged with its ID.
module datapath_rr_arbiter
  import datapath_rr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int WIDTH      = 8,
  parameter  int DP_LATENCY = 2,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     dp_enable_o,
  output logic [WIDTH-1:0]         dp_data_o,
  input  logic [WIDTH-1:0]         dp_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     busy_o
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   op_q;
  logic [WIDTH-1:0]   res_q;
  logic [ID_W-1:0]    id_q;

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               any_valid;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req       (req_valid_i),
    .ptr       (ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: every register, including the operand/result/ID holding
    // registers, is cleared so all outputs read 0 straight after reset.
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      id_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of its inputs.
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            op_q  <= req_data_i[int'(grant_idx)*WIDTH +: WIDTH];
            id_q  <= grant_idx;
            ptr_q <= (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
          end
        end
        ISSUE: cnt_q <= CNT_W'(DP_LATENCY - 1);
        WAIT: begin
          // Count reaches zero exactly DP_LATENCY cycles after the enable.
          if (cnt_q == '0) res_q <= dp_data_i;
          else             cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Grants are only offered from IDLE and never while reset is applied.
  assign req_ready_o = (state_q == IDLE && !rst_i) ? grant_oh : '0;
  assign dp_enable_o = (state_q == ISSUE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign dp_data_o   = op_q;
  assign rsp_data_o  = res_q;
  assign rsp_id_o    = id_q;

endmodule

// File: tb/tb_datapath_rr_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, randomized
// traffic against a transaction-level model, and a datapath latency sweep.
module tb_datapath_rr_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int ID_W = 2;
  localparam int NI   = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic           rsp_ready;

  logic [N-1:0]    req_ready [NI];
  logic            dp_en     [NI];
  logic [W-1:0]    dp_do     [NI];
  logic [W-1:0]    dp_di     [NI];
  logic            rsp_valid [NI];
  logic [W-1:0]    rsp_data  [NI];
  logic [ID_W-1:0] rsp_id    [NI];
  logic            busy      [NI];

  int           cyc = 0;
  int           en_cyc [NI] = '{-100, -100, -100};
  logic [W-1:0] op     [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: result ~x is presented only in the cycle exactly
  // DP_LATENCY after the enable; any other cycle shows a decoy value.
  always @(posedge clk)
    for (int k = 0; k < NI; k++)
      if (dp_en[k]) begin
        en_cyc[k] <= cyc;
        op[k]     <= dp_do[k];
      end

  always_comb
    for (int k = 0; k < NI; k++)
      dp_di[k] = (cyc == en_cyc[k] + lat_of(k)) ? ~op[k] : (op[k] ^ 8'h3C);

  datapath_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DP_LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready[0]), .dp_enable_o(dp_en[0]), .dp_data_o(dp_do[0]),
    .dp_data_i(dp_di[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data[0]), .rsp_id_o(rsp_id[0]), .busy_o(busy[0]));

  datapath_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DP_LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready[1]), .dp_enable_o(dp_en[1]), .dp_data_o(dp_do[1]),
    .dp_data_i(dp_di[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data[1]), .rsp_id_o(rsp_id[1]), .busy_o(busy[1]));

  datapath_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DP_LATENCY(15)) dut_l15 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready[2]), .dp_enable_o(dp_en[2]), .dp_data_o(dp_do[2]),
    .dp_data_i(dp_di[2]), .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data[2]), .rsp_id_o(rsp_id[2]), .busy_o(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [N*W-1:0] d, input int i);
    return d[i*W +: W];
  endfunction

  // Reference round-robin choice: first valid index at or after p, modulo N.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ready"}, req_ready[0], 0);
    check({name, " enable"}, dp_en[0], 0);
    check({name, " rsp_valid"}, rsp_valid[0], 0);
    check({name, " busy"}, busy[0], 0);
    check({name, " dp_data"}, dp_do[0], 0);
    check({name, " rsp_data"}, rsp_data[0], 0);
    check({name, " rsp_id"}, rsp_id[0], 0);
  endtask

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   exp_ready;
    int             exp_id;
  } vec_t;

  vec_t vecs [12];

  // One full transaction on the L=2 instance: grant at T, enable at T+1,
  // response at T+4, accepted immediately, IDLE again the cycle after.
  task automatic run_row(input vec_t v, input int r);
    int           k;
    logic [W-1:0] exp_rsp;
    exp_rsp = ~lane(v.data, v.exp_id);
    req_valid = v.valid; req_data = v.data; rsp_ready = 1'b1;
    #1;
    check($sformatf("row%0d grant", r), req_ready[0], v.exp_ready);
    check($sformatf("row%0d idle", r), busy[0], 0);
    @(negedge clk); req_valid = '0; #1;
    check($sformatf("row%0d enable", r), dp_en[0], 1);
    check($sformatf("row%0d operand", r), dp_do[0], lane(v.data, v.exp_id));
    k = 1;
    while (!rsp_valid[0] && k < 40) begin
      @(negedge clk); k++; #1;
    end
    check($sformatf("row%0d latency", r), k, 4);
    check($sformatf("row%0d rsp_data", r), rsp_data[0], exp_rsp);
    check($sformatf("row%0d rsp_id", r), rsp_id[0], v.exp_id);
    @(negedge clk); #1;
    check($sformatf("row%0d back idle", r), busy[0], 0);
    @(negedge clk);
  endtask

  int           exp_order [6] = '{0, 1, 2, 3, 0, 1};
  int           got, k, g;
  logic [W-1:0] hold_data, exp_d;
  logic [ID_W-1:0] hold_id;
  bit           m_busy;
  int           m_age, m_ptr, m_id;
  logic [W-1:0] m_op;
  bit           exp_rv;
  int           en_at [NI], rsp_at [NI];
  logic [W-1:0] rsp_got [NI];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Vector table, applied back to back from a fresh reset (pointer 0).
    vecs[0]  = '{4'b0100, 32'h11A52233, 4'b0100, 2};
    vecs[1]  = '{4'b1111, 32'h0, 4'b1000, 3};
    vecs[2]  = '{4'b0011, 32'h0, 4'b0001, 0};
    vecs[3]  = '{4'b0011, 32'h0, 4'b0010, 1};
    vecs[4]  = '{4'b0100, 32'h0, 4'b0100, 2};
    vecs[5]  = '{4'b0011, 32'h0, 4'b0001, 0};
    vecs[6]  = '{4'b0011, 32'h0, 4'b0010, 1};
    vecs[7]  = '{4'b1001, 32'h0, 4'b1000, 3};
    vecs[8]  = '{4'b1001, 32'h0, 4'b0001, 0};
    vecs[9]  = '{4'b0001, 32'h0, 4'b0001, 0};
    vecs[10] = '{4'b0001, 32'h0, 4'b0001, 0};
    vecs[11] = '{4'b0110, 32'h0, 4'b0010, 1};
    for (int i = 1; i < 12; i++) vecs[i].data = $urandom;

    // Reset with all requests valid: outputs stay 0 while reset is held.
    rst = 1'b1; req_valid = '1; req_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0; req_valid = '0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_row(vecs[i], i);

    // Fairness: all four valid continuously with immediate acceptance.
    do_reset(2);
    req_valid = '1; rsp_ready = 1'b1; req_data = $urandom;
    got = 0; k = 0;
    while (got < 6 && k < 200) begin
      #1;
      if (req_ready[0] != '0) begin
        check($sformatf("fair grant %0d", got), req_ready[0], 1 << exp_order[got]);
        got++;
      end
      @(negedge clk); k++;
    end
    check("fair grant count", got, 6);

    // Backpressure: response held for 5 cycles while all requesters wait.
    do_reset(2);
    req_valid = 4'b0001; req_data = $urandom; rsp_ready = 1'b0;
    exp_d = ~lane(req_data, 0);
    @(negedge clk); req_valid = '1;
    k = 0;
    #1;
    while (!rsp_valid[0] && k < 40) begin
      @(negedge clk); k++; #1;
    end
    hold_data = rsp_data[0]; hold_id = rsp_id[0];
    check("bp rsp_data", hold_data, exp_d);
    check("bp rsp_id", hold_id, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp rsp_valid", rsp_valid[0], 1);
      check("bp data stable", rsp_data[0], exp_d);
      check("bp id stable", rsp_id[0], 0);
      check("bp no grant", req_ready[0], 0);
      check("bp busy", busy[0], 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    check("bp handshake valid", rsp_valid[0], 1);
    @(negedge clk); #1;
    check("bp idle after release", busy[0], 0);
    check("bp next grant", req_ready[0], 4'b0010);
    req_valid = '0;
    repeat (10) @(negedge clk);

    // Reset mid-WAIT after a grant to requester 2 (pointer moved to 3).
    do_reset(2);
    req_valid = 4'b0100; req_data = $urandom; rsp_ready = 1'b1;
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    check("rst pre busy", busy[0], 1);
    check("rst pre in wait", dp_en[0], 0);
    rst = 1'b1; req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_all_zero($sformatf("midrst%0d", i));
    end
    rst = 1'b0; #1;
    check("rst grant to req0", req_ready[0], 4'b0001);
    @(negedge clk); req_valid = '0;
    repeat (10) @(negedge clk);

    // Randomized traffic against a transaction-level model of instance 0.
    do_reset(2);
    m_busy = 1'b0; m_age = 0; m_ptr = 0; m_id = 0; m_op = '0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g      = m_busy ? -1 : rr_pick(req_valid, m_ptr);
      exp_rv = m_busy && (m_age >= 4);
      exp_d  = ~m_op;
      check("rand grant", req_ready[0], (g >= 0) ? (1 << g) : 0);
      check("rand busy", busy[0], m_busy);
      check("rand enable", dp_en[0], m_busy && m_age == 1);
      check("rand rsp_valid", rsp_valid[0], exp_rv);
      if (m_busy && m_age == 1) check("rand operand", dp_do[0], m_op);
      if (exp_rv) begin
        check("rand rsp_data", rsp_data[0], exp_d);
        check("rand rsp_id", rsp_id[0], m_id);
      end
      if (exp_rv && rsp_ready) m_busy = 1'b0;
      else if (m_busy)         m_age++;
      if (g >= 0) begin
        m_busy = 1'b1; m_age = 1; m_id = g;
        m_op   = lane(req_data, g);
        m_ptr  = (g + 1) % N;
      end
      @(negedge clk);
    end

    // Latency sweep: DP_LATENCY 2, 1 and 15 granted in the same cycle.
    do_reset(2);
    req_valid = 4'b0010; req_data = 32'h00003C00; rsp_ready = 1'b1;
    for (int i = 0; i < NI; i++) begin en_at[i] = -1; rsp_at[i] = -1; rsp_got[i] = '0; end
    for (int t = 0; t < 40; t++) begin
      #1;
      for (int i = 0; i < NI; i++) begin
        if (dp_en[i] && en_at[i] < 0) en_at[i] = t;
        if (rsp_valid[i] && rsp_at[i] < 0) begin
          rsp_at[i]  = t;
          rsp_got[i] = rsp_data[i];
        end
      end
      @(negedge clk);
      req_valid = '0;
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("sweep L%0d enable", lat_of(i)), en_at[i], 1);
      check($sformatf("sweep L%0d latency", lat_of(i)), rsp_at[i] - en_at[i], lat_of(i) + 1);
      check($sformatf("sweep L%0d data", lat_of(i)), rsp_got[i], 8'hC3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
